// File: rtl/code_entry_buffer_pkg.sv
// Shared lock package: BCD digit type, digit limit and the factory access code
// used by the code entry buffer and the lock control bench.
package code_entry_buffer_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t       MAX_DIGIT         = 4'd9;
  localparam logic [15:0]      LOCK_DEFAULT_CODE = 16'h1234;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= MAX_DIGIT);
  endfunction

endpackage

// File: rtl/code_entry_buffer.sv
// Keypad-side digit collector for the lock controller: shifts in BCD digits,
// reports full/match, flushes on clear or a result. Optional code
// reprogramming is enabled by defining CODE_PROG_EN.
module code_entry_buffer
  import code_entry_buffer_pkg::*;
#(
  parameter int                    CODE_LEN     = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = LOCK_DEFAULT_CODE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ready_for_input,
  input  logic                          unlock_led,
  input  logic                          fail_led,
  input  logic                          digit_valid,
  input  logic [3:0]                    digit,
  input  logic                          clear,
`ifdef CODE_PROG_EN
  input  logic                          prog_req,
  output logic                          prog_done,
`endif
  output logic                          full,
  output logic                          match,
  output logic [$clog2(CODE_LEN+1)-1:0] digit_count,
  output logic                          digit_err
);

  localparam int W  = 4 * CODE_LEN;
  localparam int CW = $clog2(CODE_LEN + 1);

  logic [W-1:0]  buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          match_q, match_d;
  logic          err_q, err_d;
  logic [W-1:0]  code_s;
  logic          flush_s, offer_s, load_s;
  logic [W+3:0]  shifted_s;

`ifdef CODE_PROG_EN
  logic [W-1:0]  code_q, code_d;
  logic          armed_q, armed_d;
  logic          done_q, done_d;

  assign code_s = code_q;
  assign load_s = prog_req && armed_q && full_q;
`else
  assign code_s = DEFAULT_CODE;
  assign load_s = 1'b0;
`endif

  assign flush_s   = clear || unlock_led || fail_led;
  assign offer_s   = digit_valid && ready_for_input && !full_q;
  // Wide concatenation keeps the shift legal even for a one-digit code.
  assign shifted_s = {buf_q, digit};

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (flush_s || load_s) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (offer_s && is_bcd(digit)) begin
      buf_d = shifted_s[W-1:0];
      cnt_d = cnt_q + CW'(1);
    end else if (offer_s) begin
      err_d = 1'b1;
    end else begin
      buf_d = buf_q;
    end
    full_d  = (cnt_d == CW'(CODE_LEN));
    match_d = full_d && (buf_d == code_s);
  end

`ifdef CODE_PROG_EN
  // A flush outranks a load, so a load can never coincide with unlock_led.
  always_comb begin
    code_d  = code_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    if (!flush_s && load_s) begin
      code_d  = buf_q;
      armed_d = 1'b0;
      done_d  = 1'b1;
    end else if (unlock_led) begin
      armed_d = 1'b1;
    end else if (fail_led || clear) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= DEFAULT_CODE;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      code_q  <= code_d;
      armed_q <= armed_d;
      done_q  <= done_d;
    end
  end

  assign prog_done = done_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  assign full        = full_q;
  assign match       = match_q;
  assign digit_count = cnt_q;
  assign digit_err   = err_q;

endmodule
